reg_block_axil_arbiter: RTL

Shares the single AXI4-Lite slave port (S00_AXI) of `reg_block` between N simple register-access requesters, such as the firmware command decoder and the status poller. The block runs round-robin arbitration, converts one granted request into a complete AXI4-Lite write or read transaction, and returns completion status and read data to the requester. It sits between the requesters and the `reg_block` slave interface, with one transaction outstanding at a time.

---
 rtl/reg_block_arb_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/reg_block_axil_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/reg_block_arb_pkg.sv
// Shared types and constants for the reg_block AXI4-Lite requester arbiter.
package reg_block_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Full-word writes only; unprivileged, secure, data accesses.
  localparam logic [3:0] WSTRB_ALL    = 4'hF;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requesting bit at or above ptr, with wrap.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt
);

  int   idx;
  logic found;

  // Scan upward from ptr; the first hit wins and masks all later candidates.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_block_axil_arbiter.sv
// Shares one AXI4-Lite master port between N_REQ register requesters,
// one transaction in flight, round-robin arbitration, registered outputs.
module reg_block_axil_arbiter
  import reg_block_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_write,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            req_done,
  output logic [DATA_WIDTH-1:0]       rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic [N_REQ-1:0]            grant,
  output logic                        busy,
  output logic [ADDR_WIDTH-1:0]       M_AXI_AWADDR,
  output logic [2:0]                  M_AXI_AWPROT,
  output logic                        M_AXI_AWVALID,
  input  logic                        M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]       M_AXI_WDATA,
  output logic [3:0]                  M_AXI_WSTRB,
  output logic                        M_AXI_WVALID,
  input  logic                        M_AXI_WREADY,
  input  logic [1:0]                  M_AXI_BRESP,
  input  logic                        M_AXI_BVALID,
  output logic                        M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]       M_AXI_ARADDR,
  output logic [2:0]                  M_AXI_ARPROT,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]       M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t                state_q;
  logic [N_REQ-1:0]      grant_q;
  logic [PTR_W-1:0]      gidx_q;
  logic [PTR_W-1:0]      rr_ptr_q;
  logic [PTR_W-1:0]      rr_ptr_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic [N_REQ-1:0]      done_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            resp_q;
  logic                  busy_q;

  logic [N_REQ-1:0]      arb_gnt;
  logic [PTR_W-1:0]      arb_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_write;
  logic                  aw_done, w_done;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt)
  );

  // Mux the winner's payload and index out of the packed request buses.
  always_comb begin
    arb_idx   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        arb_idx   = PTR_W'(i);
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_write = req_write[i];
      end
    end
  end

  // A write channel counts as finished if already handshaken or handshaking now.
  assign aw_done  = !awvalid_q || M_AXI_AWREADY;
  assign w_done   = !wvalid_q || M_AXI_WREADY;
  assign rr_ptr_d = (gidx_q == PTR_W'(N_REQ - 1)) ? '0 : gidx_q + PTR_W'(1);

  // Transaction FSM: capture the winner, run the AXI handshakes, pulse completion.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      rr_ptr_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      done_q    <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req_valid) begin
            grant_q <= arb_gnt;
            gidx_q  <= arb_idx;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            busy_q  <= 1'b1;
            if (sel_write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_WR_REQ;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= ST_RD_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          if (awvalid_q && M_AXI_AWREADY) awvalid_q <= 1'b0;
          if (wvalid_q && M_AXI_WREADY)   wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (M_AXI_BVALID) begin
            bready_q <= 1'b0;
            resp_q   <= M_AXI_BRESP;
            rdata_q  <= '0;
            done_q   <= grant_q;
            state_q  <= ST_DONE;
          end
        end
        ST_RD_REQ: begin
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (M_AXI_RVALID) begin
            rready_q <= 1'b0;
            resp_q   <= M_AXI_RRESP;
            rdata_q  <= M_AXI_RDATA;
            done_q   <= grant_q;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q   <= '0;
          grant_q  <= '0;
          busy_q   <= 1'b0;
          rr_ptr_q <= rr_ptr_d;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_done      = done_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign grant         = grant_q;
  assign busy          = busy_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
  assign M_AXI_WSTRB   = WSTRB_ALL;
  assign M_AXI_AWPROT  = PROT_DEFAULT;
  assign M_AXI_ARPROT  = PROT_DEFAULT;

endmodule
